// File: rtl/defuzz_wavg.sv
// Weighted-average defuzzifier: sum(mu_i*s_i)/sum(mu_i) for three singleton rules,
// using one time-shared 16x8 multiplier and an 8-step restoring divider.
module defuzz_wavg (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       mu_neg,
  input  logic [15:0]       mu_zero,
  input  logic [15:0]       mu_pos,
  input  logic signed [7:0] s_neg,
  input  logic signed [7:0] s_zero,
  input  logic signed [7:0] s_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] y,
  output logic              zero_den
);

  typedef enum logic [2:0] {IDLE, MAC, PREP, DIV, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]        mu_n_c, mu_z_c, mu_p_c;
  logic signed [7:0]  s_n_c, s_z_c, s_p_c;
  logic [1:0]         term_cnt;
  logic [2:0]         bit_cnt;
  logic signed [25:0] num_acc;
  logic [17:0]        den_acc;
  logic               num_neg;
  logic [25:0]        rem;
  logic [25:0]        dvs;
  logic [7:0]         quo;

  logic [15:0]        mul_a;
  logic signed [7:0]  mul_b;
  logic signed [23:0] mul_a_ext, mul_b_ext, prod;
  logic               rem_ge;
  logic [7:0]         quo_nxt;

  function automatic logic [25:0] abs_num(input logic signed [25:0] v);
    logic [25:0] u;
    u = v;
    return v[25] ? (~u + 26'd1) : u;
  endfunction

  function automatic logic signed [7:0] apply_sign(input logic [7:0] mag, input logic neg);
    logic [7:0] r;
    r = neg ? (~mag + 8'd1) : mag;
    return $signed(r);
  endfunction

  // Operand select for the shared multiplier: neg, zero, pos in successive MAC cycles
  always_comb begin
    mul_a = mu_n_c;
    mul_b = s_n_c;
    case (term_cnt)
      2'd1:    begin mul_a = mu_z_c; mul_b = s_z_c; end
      2'd2:    begin mul_a = mu_p_c; mul_b = s_p_c; end
      default: begin mul_a = mu_n_c; mul_b = s_n_c; end
    endcase
  end

  assign mul_a_ext = $signed({8'd0, mul_a});
  assign mul_b_ext = {{16{mul_b[7]}}, mul_b};
  assign prod      = mul_a_ext * mul_b_ext;
  assign rem_ge    = (rem >= dvs);
  assign quo_nxt   = {quo[6:0], rem_ge};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = MAC;
      MAC:  if (term_cnt == 2'd2) state_nxt = PREP;
      PREP: state_nxt = (den_acc == 18'd0) ? DONE : DIV;
      DIV:  if (bit_cnt == 3'd7) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mu_n_c   <= '0;
      mu_z_c   <= '0;
      mu_p_c   <= '0;
      s_n_c    <= '0;
      s_z_c    <= '0;
      s_p_c    <= '0;
      term_cnt <= '0;
      bit_cnt  <= '0;
      num_acc  <= '0;
      den_acc  <= '0;
      num_neg  <= 1'b0;
      rem      <= '0;
      dvs      <= '0;
      quo      <= '0;
      y        <= '0;
      zero_den <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mu_n_c   <= mu_neg;
          mu_z_c   <= mu_zero;
          mu_p_c   <= mu_pos;
          s_n_c    <= s_neg;
          s_z_c    <= s_zero;
          s_p_c    <= s_pos;
          num_acc  <= '0;
          den_acc  <= '0;
          term_cnt <= '0;
          zero_den <= 1'b0;
        end
        MAC: begin
          num_acc  <= num_acc + {{2{prod[23]}}, prod};
          den_acc  <= den_acc + {2'b00, mul_a};
          term_cnt <= term_cnt + 2'd1;
        end
        PREP: if (den_acc == 18'd0) begin
          y        <= '0;
          zero_den <= 1'b1;
        end else begin
          num_neg <= num_acc[25];
          rem     <= abs_num(num_acc);
          // Divisor starts at den*2^7 so the first step yields quotient bit 7
          dvs     <= {1'b0, den_acc, 7'd0};
          quo     <= '0;
          bit_cnt <= '0;
        end
        DIV: begin
          if (rem_ge) rem <= rem - dvs;
          dvs     <= dvs >> 1;
          quo     <= quo_nxt;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) y <= apply_sign(quo_nxt, num_neg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_defuzz_wavg.sv
// Randomized and directed bench for defuzz_wavg against an integer-arithmetic model.
module tb_defuzz_wavg;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       mu_neg = '0, mu_zero = '0, mu_pos = '0;
  logic signed [7:0] s_neg = '0, s_zero = '0, s_pos = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] y;
  logic              zero_den;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  defuzz_wavg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mu_neg(mu_neg), .mu_zero(mu_zero), .mu_pos(mu_pos),
    .s_neg(s_neg), .s_zero(s_zero), .s_pos(s_pos),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero_den(zero_den)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    mu_neg  = 16'($urandom);
    mu_zero = 16'($urandom);
    mu_pos  = 16'($urandom);
    s_neg   = 8'($urandom);
    s_zero  = 8'($urandom);
    s_pos   = 8'($urandom);
  endtask

  // Present one set, wait for the result, hold it for 'hold' cycles, then release.
  task automatic txn(input string tag, input logic [15:0] m0, m1, m2,
                     input logic signed [7:0] a0, a1, a2, input int hold);
    int num, den, ey, ezd, lat;
    num = int'(m0) * int'(a0) + int'(m1) * int'(a1) + int'(m2) * int'(a2);
    den = int'(m0) + int'(m1) + int'(m2);
    if (den == 0) begin ey = 0; ezd = 1; end
    else begin ey = num / den; ezd = 0; end

    mu_neg = m0; mu_zero = m1; mu_pos = m2;
    s_neg = a0; s_zero = a1; s_pos = a2;
    in_valid = 1'b1;
    chk({tag, " in_ready before accept"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    scramble();
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, (ezd != 0) ? 4 : 12);
    chk({tag, " y"}, int'(y), ey);
    chk({tag, " zero_den"}, int'(zero_den), ezd);
    chk({tag, " in_ready in DONE"}, int'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " hold out_valid"}, int'(out_valid), 1);
      chk({tag, " hold y"}, int'(y), ey);
      chk({tag, " hold zero_den"}, int'(zero_den), ezd);
      chk({tag, " hold in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid after handshake"}, int'(out_valid), 0);
    chk({tag, " in_ready after handshake"}, int'(in_ready), 1);
    chk({tag, " y retained in idle"}, int'(y), ey);
  endtask

  initial begin
    logic [15:0] rm0, rm1, rm2;

    rst_n = 1'b0;
    tick();
    tick();
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset y", int'(y), 0);
    chk("reset zero_den", int'(zero_den), 0);
    rst_n = 1'b1;

    txn("single_pos",  16'h0000, 16'h0000, 16'h8000, 8'sd5, -8'sd7, 8'sd100, 0);
    txn("symmetric",   16'h4000, 16'h0000, 16'h4000, -8'sd100, 8'sd0, 8'sd100, 0);
    txn("quarter_neg", 16'h2000, 16'h6000, 16'h0000, -8'sd128, 8'sd0, 8'sd77, 1);
    txn("trunc_pos",   16'd1, 16'd0, 16'd2, -8'sd10, 8'sd0, 8'sd10, 0);
    txn("trunc_neg",   16'd1, 16'd0, 16'd2, 8'sd10, 8'sd0, -8'sd10, 0);
    txn("extreme_neg", 16'hFFFF, 16'hFFFF, 16'hFFFF, -8'sd128, -8'sd128, -8'sd128, 0);
    txn("extreme_pos", 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'sd127, 8'sd127, 8'sd127, 0);
    txn("zero_den",    16'd0, 16'd0, 16'd0, 8'sd50, -8'sd3, 8'sd9, 0);
    txn("backpressure", 16'h1234, 16'h0F00, 16'h7777, -8'sd90, 8'sd20, 8'sd45, 5);
    txn("after_zd",    16'd3, 16'd0, 16'd0, 8'sd0, 8'sd0, -8'sd9, 0);

    // Reset while the divider is running
    mu_neg = 16'h0100; mu_zero = 16'h0000; mu_pos = 16'h0300;
    s_neg = -8'sd40; s_zero = 8'sd0; s_pos = 8'sd120;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst in_ready", int'(in_ready), 1);
    chk("midrst y", int'(y), 0);
    chk("midrst zero_den", int'(zero_den), 0);
    in_valid = 1'b1;
    tick();
    chk("in_valid ignored in reset", int'(in_ready), 1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("no output after reset", int'(out_valid), 0);
    end
    txn("post_reset", 16'h0100, 16'h0000, 16'h0300, -8'sd40, 8'sd0, 8'sd120, 0);

    for (int k = 0; k < 40; k++) begin
      rm0 = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      rm1 = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      rm2 = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin rm0 = 16'($urandom_range(0, 5)); rm1 = 16'd0; end
      txn($sformatf("rand%0d", k), rm0, rm1, rm2,
          8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/defuzz_wavg.md
DEFUZZ_WAVG -- requirements
Module: defuzz_wavg

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  caller presents a rule-strength set.
REQ-005 in_ready  output  1  block can accept a set this cycle.
REQ-006 mu_neg, mu_zero, mu_pos  input  16 each  rule strengths, unsigned Q1.15 (0x8000 = 1.0; any 16-bit value legal).
REQ-007 s_neg, s_zero, s_pos  input  8 each, signed  output singleton positions.
REQ-008 out_valid  output  1  y and zero_den are valid.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 y  output  8, signed  crisp output.
REQ-011 zero_den  output  1  sum of strengths was zero; y forced to 0.

Function
REQ-012 Result SHALL be y = trunc_toward_zero( (mu_neg*s_neg + mu_zero*s_zero + mu_pos*s_pos) / (mu_neg + mu_zero + mu_pos) ).
REQ-013 Numerator SHALL be a 26-bit signed accumulator of 24-bit signed 16x8 products; denominator SHALL be 18-bit unsigned; no overflow is possible at these widths.
REQ-014 Only one 16x8 multiplier SHALL be instantiated and time-shared across the three terms.
REQ-015 States: IDLE, MAC, PREP, DIV, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready, all six data inputs SHALL be registered, the accumulators cleared, and the state goes to MAC.
REQ-017 MAC: 3 cycles, one term added per cycle (neg, zero, pos order), then PREP.
REQ-018 PREP: 1 cycle; if the denominator equals 0, set y=0 and zero_den=1 and go to DONE; otherwise latch the numerator sign and |numerator| and go to DIV.
REQ-019 DIV: restoring divide of |num| by den, 8 iterations at 1 quotient bit per cycle, MSB first, then DONE; |num| <= 128*den guarantees an 8-bit magnitude quotient.
REQ-020 On DIV exit, y SHALL be the quotient, negated when the numerator was negative; -128 is reachable, and +128 cannot occur because singletons are limited to 127.
REQ-021 DONE: out_valid=1; y and zero_den held stable; on out_valid&&out_ready go to IDLE.
REQ-022 in_ready SHALL be 0 in every state except IDLE; no accept occurs in the same cycle as a DONE handshake.
REQ-023 Latency: out_valid SHALL rise 12 edges after the accepting edge for nonzero den, and 4 edges after it for zero den.
REQ-024 Input changes after acceptance SHALL NOT affect the in-flight result.
REQ-025 zero_den SHALL be cleared on the next accept; y SHALL retain its last value in IDLE.

Reset
REQ-026 When rst_n=0 at a rising edge, the next state SHALL be: state=IDLE, in_ready=1, out_valid=0, y=0, zero_den=0, and accumulators, divider and captured inputs cleared.
REQ-027 Reset SHALL take effect from any state, including mid-MAC or mid-DIV; the in-flight result is discarded and out_valid is not raised.
REQ-028 While rst_n=0, in_valid SHALL be ignored.

Verification
REQ-029 mu=(0,0,0x8000), s_pos=100 -> out_valid 12 edges after accept, y=100, zero_den=0.
REQ-030 mu=(0x4000,0,0x4000), s=(-100,0,100) -> y=0; mu=(0x2000,0x6000,0), s=(-128,0,x) -> y=-32.
REQ-031 Truncation checks:
- mu=(1,0,2), s=(-10,0,10) -> num 10, den 3 -> y=3.
- mu=(1,0,2), s=(10,0,-10) -> y=-3.
REQ-032 Extremes and zero denominator:
- All mu=0xFFFF, all s=-128 -> y=-128.
- All mu=0 -> y=0, zero_den=1, out_valid 4 edges after accept.
REQ-033 Backpressure: out_ready held low 5 cycles in DONE -> out_valid, y and zero_den stable and in_ready=0 throughout; handshake -> in_ready=1 the next cycle.
REQ-034 Reset mid-operation: rst_n=0 on the 7th edge after accept (DIV) -> following cycle out_valid=0, in_ready=1, y=0; a new accept then completes normally.
